// File: rtl/invader_march_ctrl.sv
// Formation march scheduler: paces formation steps from move ticks, sweeps the
// formation right/left with a row drop at each edge, and flags landing/clear.
// Latency: outputs registered, a qualifying step Tick at edge k updates offsets and Step at edge k.
// Backpressure: none; EN=0 freezes all state and Ticks seen while paused are discarded.
// Ports: CLK/Rst (async active-low) | EN, Tick, Alive[5:0], Restart in |
//        X_Off, Y_Off, Dir (1=left), Step (1-cycle pulse), Landed (sticky) out
module invader_march_ctrl #(
  parameter int X_MAX  = 64,
  parameter int X_STEP = 4,
  parameter int Y_STEP = 8,
  parameter int Y_MAX  = 120,
  parameter int XW     = 8,
  parameter int YW     = 8
) (
  input  logic          CLK,
  input  logic          Rst,
  input  logic          EN,
  input  logic          Tick,
  input  logic [5:0]    Alive,
  input  logic          Restart,
  output logic [XW-1:0] X_Off,
  output logic [YW-1:0] Y_Off,
  output logic          Dir,
  output logic          Step,
  output logic          Landed
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    MARCH_R = 3'd1,
    MARCH_L = 3'd2,
    LANDED  = 3'd3,
    CLEAR   = 3'd4
  } state_t;

  // Edge tests are done one bit wider so X_Off + X_STEP cannot wrap.
  localparam logic [XW:0]   X_MAX_W  = (XW+1)'(X_MAX);
  localparam logic [XW:0]   X_STEP_W = (XW+1)'(X_STEP);
  localparam logic [XW-1:0] X_STEP_N = XW'(X_STEP);
  localparam logic [YW:0]   Y_MAX_W  = (YW+1)'(Y_MAX);
  localparam logic [YW:0]   Y_STEP_W = (YW+1)'(Y_STEP);
  localparam logic [YW-1:0] Y_MAX_N  = YW'(Y_MAX);

  state_t        state, state_nxt;
  logic [3:0]    pace_cnt, pace_cnt_nxt;
  logic [3:0]    pace_lim;
  logic [XW:0]   x_sum;
  logic [YW:0]   y_sum;
  logic [XW-1:0] x_nxt;
  logic [YW-1:0] y_nxt;
  logic          dir_nxt, step_nxt, landed_nxt;
  logic          at_edge;

  // Fewer invaders -> smaller limit -> faster march; sampled live each Tick.
  assign pace_lim = Alive[5:2];
  assign x_sum    = {1'b0, X_Off} + X_STEP_W;
  assign y_sum    = {1'b0, Y_Off} + Y_STEP_W;

  always_ff @(posedge CLK or negedge Rst) begin
    if (!Rst) begin
      state    <= IDLE;
      pace_cnt <= '0;
      X_Off    <= '0;
      Y_Off    <= '0;
      Dir      <= 1'b0;
      Step     <= 1'b0;
      Landed   <= 1'b0;
    end else begin
      state    <= state_nxt;
      pace_cnt <= pace_cnt_nxt;
      X_Off    <= x_nxt;
      Y_Off    <= y_nxt;
      Dir      <= dir_nxt;
      Step     <= step_nxt;
      Landed   <= landed_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    pace_cnt_nxt = pace_cnt;
    x_nxt        = X_Off;
    y_nxt        = Y_Off;
    dir_nxt      = Dir;
    step_nxt     = 1'b0;
    landed_nxt   = Landed;
    at_edge      = 1'b0;

    if (Restart) begin
      state_nxt    = IDLE;
      pace_cnt_nxt = '0;
      x_nxt        = '0;
      y_nxt        = '0;
      dir_nxt      = 1'b0;
      landed_nxt   = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (EN && (Alive != '0)) state_nxt = MARCH_R;
        end
        MARCH_R, MARCH_L: begin
          if (Alive == '0) begin
            // Wave cleared: freeze offsets, suppress any coincident step.
            state_nxt = CLEAR;
          end else if (EN && Tick) begin
            // >= (not ==) so a limit lowered below the count steps at once.
            if (pace_cnt >= pace_lim) begin
              pace_cnt_nxt = '0;
              step_nxt     = 1'b1;
              if (state == MARCH_R) begin
                at_edge = (x_sum > X_MAX_W);
                if (at_edge) begin
                  dir_nxt   = 1'b1;
                  state_nxt = MARCH_L;
                end else begin
                  x_nxt = x_sum[XW-1:0];
                end
              end else begin
                at_edge = (X_Off < X_STEP_N);
                if (at_edge) begin
                  dir_nxt   = 1'b0;
                  state_nxt = MARCH_R;
                end else begin
                  x_nxt = X_Off - X_STEP_N;
                end
              end
              if (at_edge) begin
                // A drop that would reach the floor clamps and lands.
                if (y_sum >= Y_MAX_W) begin
                  y_nxt      = Y_MAX_N;
                  landed_nxt = 1'b1;
                  state_nxt  = LANDED;
                end else begin
                  y_nxt = y_sum[YW-1:0];
                end
              end
            end else begin
              pace_cnt_nxt = pace_cnt + 4'd1;
            end
          end
        end
        default: ; // LANDED and CLEAR hold until Restart or Rst
      endcase
    end
  end

endmodule

// File: tb/tb_invader_march_ctrl.sv
module tb_invader_march_ctrl;

  localparam int X_MAX  = 64;
  localparam int X_STEP = 4;
  localparam int Y_STEP = 8;
  localparam int Y_MAX  = 120;

  logic       CLK = 1'b0;
  logic       Rst;
  logic       EN, Tick, Restart;
  logic [5:0] Alive;
  logic [7:0] X_Off, Y_Off;
  logic       Dir, Step, Landed;

  int checks = 0;
  int errors = 0;

  invader_march_ctrl #(
    .X_MAX(X_MAX), .X_STEP(X_STEP), .Y_STEP(Y_STEP), .Y_MAX(Y_MAX), .XW(8), .YW(8)
  ) dut (
    .CLK(CLK), .Rst(Rst), .EN(EN), .Tick(Tick), .Alive(Alive), .Restart(Restart),
    .X_Off(X_Off), .Y_Off(Y_Off), .Dir(Dir), .Step(Step), .Landed(Landed)
  );

  always #5 CLK = ~CLK;

  // Reference model: formation position as plain integers.
  // mode: 0 waiting, 1 marching, 2 landed, 3 cleared
  int mode, mx, my, mcnt;
  bit mdir, mstep, mland;

  task automatic model_reset();
    mode = 0; mx = 0; my = 0; mcnt = 0; mdir = 0; mstep = 0; mland = 0;
  endtask

  task automatic model_edge(bit en, bit tick, int alive, bit rs);
    mstep = 0;
    if (rs) begin
      model_reset();
      return;
    end
    case (mode)
      0: if (en && alive != 0) mode = 1;
      1: begin
        if (alive == 0) mode = 3;
        else if (en && tick) begin
          if (mcnt >= alive / 4) begin
            mcnt  = 0;
            mstep = 1;
            if (mdir ? (mx < X_STEP) : (mx + X_STEP > X_MAX)) begin
              mdir = !mdir;
              if (my + Y_STEP >= Y_MAX) begin
                my = Y_MAX; mland = 1; mode = 2;
              end else my = my + Y_STEP;
            end else mx = mdir ? mx - X_STEP : mx + X_STEP;
          end else mcnt++;
        end
      end
      default: ;
    endcase
  endtask

  function automatic string dut_s();
    return $sformatf("x=%0d y=%0d dir=%0d step=%0d landed=%0d", X_Off, Y_Off, Dir, Step, Landed);
  endfunction

  function automatic string mod_s();
    return $sformatf("x=%0d y=%0d dir=%0d step=%0d landed=%0d", mx, my, mdir, mstep, mland);
  endfunction

  // One clock with the given inputs; returns 1 ns after the edge.
  task automatic drive(bit en, bit tick, int alive, bit rs);
    EN = en; Tick = tick; Alive = 6'(alive); Restart = rs;
    @(posedge CLK);
    model_edge(en, tick, alive, rs);
    #1;
  endtask

  task automatic restart_and_start(int alive);
    drive(1'b0, 1'b0, alive, 1'b1);
    drive(1'b1, 1'b0, alive, 1'b0);
  endtask

  task automatic test_reset();
    Rst = 1'b0; EN = 0; Tick = 0; Alive = 0; Restart = 0;
    model_reset();
    #12;
    checks++;
    if ({X_Off, Y_Off, Dir, Step, Landed} !== 19'd0) begin
      errors++; $display("FAIL reset_state: got %s, want all zero", dut_s());
    end
    Rst = 1'b1;
  endtask

  task automatic test_reset_mid_march();
    restart_and_start(3);
    for (int i = 0; i < 6; i++) drive(1'b1, 1'b1, 3, 1'b0);
    checks++;
    if (X_Off !== 8'd24 || X_Off !== 8'(mx)) begin
      errors++; $display("FAIL mid_march_x24: got %s, want %s", dut_s(), mod_s());
    end
    #2 Rst = 1'b0;
    #1;
    checks++;
    if ({X_Off, Y_Off, Dir, Step, Landed} !== 19'd0) begin
      errors++; $display("FAIL async_reset: got %s, want all zero", dut_s());
    end
    #2 Rst = 1'b1;
    model_reset();
    drive(1'b1, 1'b1, 3, 1'b0);  // waiting state: this Tick must not step
    checks++;
    if (Step !== 1'b0 || X_Off !== 8'd0 || Step !== mstep) begin
      errors++; $display("FAIL idle_after_reset: got %s, want %s", dut_s(), mod_s());
    end
    drive(1'b1, 1'b1, 3, 1'b0);
    checks++;
    if (Step !== 1'b1 || X_Off !== 8'd4 || X_Off !== 8'(mx)) begin
      errors++; $display("FAIL first_step_after_reset: got %s, want x=4 step=1", dut_s());
    end
  endtask

  task automatic test_right_sweep();
    int steps = 0;
    restart_and_start(3);
    for (int i = 1; i <= 17; i++) begin
      drive(1'b1, 1'b1, 3, 1'b0);
      steps += Step;
      checks++;
      if ({X_Off, Y_Off, Dir, Step, Landed} !== {8'(mx), 8'(my), mdir, mstep, mland}) begin
        errors++; $display("FAIL sweep tick %0d: got %s, want %s", i, dut_s(), mod_s());
      end
    end
    checks++;
    if (X_Off !== 8'd64 || Y_Off !== 8'd8 || Dir !== 1'b1 || Step !== 1'b1 || steps != 17) begin
      errors++; $display("FAIL sweep_drop: got %s steps=%0d, want x=64 y=8 dir=1 step=1 steps=17", dut_s(), steps);
    end
    drive(1'b1, 1'b1, 3, 1'b0);
    checks++;
    if (X_Off !== 8'd60 || Dir !== 1'b1) begin
      errors++; $display("FAIL sweep_left: got %s, want x=60 dir=1", dut_s());
    end
  endtask

  task automatic test_pacing();
    int got;
    got = 0;
    restart_and_start(20);
    for (int i = 1; i <= 18; i++) begin
      drive(1'b1, 1'b1, 20, 1'b0);
      if (Step) got = got * 100 + i;
      drive(1'b1, 1'b0, 20, 1'b0);  // gap cycle between Ticks
    end
    checks++;
    if (got != 61218) begin
      errors++; $display("FAIL pacing_ticks: got step-tick code %0d, want 61218 (ticks 6,12,18)", got);
    end
    restart_and_start(20);
    got = 0;
    for (int i = 1; i <= 13; i++) begin
      drive(1'b1, 1'b1, 20, 1'b0);
      got += Step;
    end
    drive(1'b1, 1'b1, 3, 1'b0);
    checks++;
    if (Step !== 1'b1 || got != 2 || Step !== mstep) begin
      errors++; $display("FAIL pacing_kill: tick14 step=%0d prior=%0d, want step=1 prior=2", Step, got);
    end
  endtask

  task automatic test_landing();
    int n = 0;
    restart_and_start(3);
    while (!Landed && n < 400) begin
      drive(1'b1, 1'b1, 3, 1'b0);
      n++;
      checks++;
      if ({X_Off, Y_Off, Dir, Step, Landed} !== {8'(mx), 8'(my), mdir, mstep, mland}) begin
        errors++; $display("FAIL landing tick %0d: got %s, want %s", n, dut_s(), mod_s());
      end
    end
    checks++;
    if (n != 255 || Y_Off !== 8'd120 || Landed !== 1'b1 || Step !== 1'b1) begin
      errors++; $display("FAIL land_point: ticks=%0d %s, want ticks=255 y=120 landed=1 step=1", n, dut_s());
    end
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b1, 3, 1'b0);
      checks++;
      if (Step !== 1'b0 || Y_Off !== 8'd120 || Landed !== 1'b1) begin
        errors++; $display("FAIL landed_hold: got %s, want step=0 y=120 landed=1", dut_s());
      end
    end
    drive(1'b1, 1'b1, 3, 1'b1);
    checks++;
    if ({X_Off, Y_Off, Dir, Step, Landed} !== 19'd0) begin
      errors++; $display("FAIL landed_restart: got %s, want all zero", dut_s());
    end
  endtask

  task automatic test_wave_clear();
    restart_and_start(3);
    for (int i = 0; i < 10; i++) drive(1'b1, 1'b1, 3, 1'b0);
    drive(1'b1, 1'b1, 0, 1'b0);
    checks++;
    if (Step !== 1'b0 || X_Off !== 8'd40 || Y_Off !== 8'd0) begin
      errors++; $display("FAIL clear_tick: got %s, want x=40 y=0 step=0", dut_s());
    end
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b1, 3, 1'b0);
    checks++;
    if (Step !== 1'b0 || X_Off !== 8'd40 || X_Off !== 8'(mx)) begin
      errors++; $display("FAIL clear_frozen: got %s, want x=40 step=0", dut_s());
    end
    restart_and_start(3);
    drive(1'b1, 1'b1, 3, 1'b0);
    checks++;
    if (X_Off !== 8'd4 || Step !== 1'b1 || Y_Off !== 8'd0) begin
      errors++; $display("FAIL clear_restart_march: got %s, want x=4 y=0 step=1", dut_s());
    end
  endtask

  task automatic test_pause();
    logic [7:0] x0;
    restart_and_start(8);               // limit 2: step every third Tick
    drive(1'b1, 1'b1, 8, 1'b0);         // count now 1
    x0 = X_Off;
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 1'b1, 8, 1'b0);
      checks++;
      if (Step !== 1'b0 || X_Off !== x0) begin
        errors++; $display("FAIL pause_hold %0d: got %s, want x=%0d step=0", i, dut_s(), x0);
      end
    end
    drive(1'b1, 1'b1, 8, 1'b0);
    checks++;
    if (Step !== 1'b0) begin
      errors++; $display("FAIL pause_resume1: step=%0d, want 0", Step);
    end
    drive(1'b1, 1'b1, 8, 1'b0);
    checks++;
    if (Step !== 1'b1 || X_Off !== 8'd4) begin
      errors++; $display("FAIL pause_resume2: got %s, want x=4 step=1", dut_s());
    end
  endtask

  task automatic test_back_to_back();
    restart_and_start(3);
    drive(1'b1, 1'b1, 3, 1'b0);
    drive(1'b1, 1'b1, 3, 1'b1);         // Restart beats the coincident Tick
    checks++;
    if (Step !== 1'b0 || X_Off !== 8'd0) begin
      errors++; $display("FAIL restart_vs_tick: got %s, want x=0 step=0", dut_s());
    end
  endtask

  task automatic test_random();
    bit en, tick, rs;
    int alive, r;
    for (int c = 0; c < 3000; c++) begin
      en   = ($urandom % 8) != 0;
      tick = $urandom % 2;
      rs   = ($urandom % 200) == 0;
      r    = $urandom % 100;
      alive = (r < 3) ? 0 : (r < 60) ? 3 : $urandom_range(1, 55);
      drive(en, tick, alive, rs);
      checks++;
      if ({X_Off, Y_Off, Dir, Step, Landed} !== {8'(mx), 8'(my), mdir, mstep, mland}) begin
        errors++; $display("FAIL random cyc %0d: got %s, want %s", c, dut_s(), mod_s());
      end
    end
  endtask

  initial begin
    test_reset();
    test_reset_mid_march();
    test_right_sweep();
    test_pacing();
    test_landing();
    test_wave_clear();
    test_pause();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/invader_march_ctrl.md
# invader_march_ctrl

Formation-march scheduler for the invader block. It consumes the move-tick pulse produced by the movement counter and decides when and where the whole formation steps: right across the field, drop one row, left across, drop, and so on. As invaders are destroyed it paces steps faster. It flags landing and cleared-wave conditions to the game FSM. Its offsets feed the invader sprite renderer.

## Interface
- X_MAX, 64: rightmost horizontal offset (pixels)
- X_STEP, 4: horizontal step size
- Y_STEP, 8: vertical drop per edge hit
- Y_MAX, 120: vertical offset at which the formation has landed
- XW, 8: X_Off width; must hold X_MAX + X_STEP
- YW, 8: Y_Off width; must hold Y_MAX + Y_STEP
- CLK  in  1  system clock; all state changes on rising edge
- Rst  in  1  asynchronous, active-low reset
- EN  in  1  march enable (0 = pause; all state frozen)
- Tick  in  1  one-cycle move pulse from the movement counter
- Alive  in  6  invaders still alive (0..55)
- Restart  in  1  synchronous wave restart
- X_Off  out  XW  formation horizontal offset
- Y_Off  out  YW  formation vertical offset
- Dir  out  1  0 = moving right, 1 = moving left
- Step  out  1  one-cycle pulse on every step or drop (drives the march sound and sprite frame toggle)
- Landed  out  1  sticky: formation reached Y_MAX

## Operation
- States: IDLE, MARCH_R, MARCH_L, LANDED, CLEAR.
- Reset (Rst=0, async): state IDLE; X_Off=0, Y_Off=0, Dir=0, Step=0, Landed=0, pace_cnt=0.
- Priority, highest first: Rst, Restart, Alive==0, EN=0, step logic.
- Restart: same values as reset, state IDLE, taken at the next edge from any state.
- IDLE -> MARCH_R when EN=1 and Alive!=0.
- Pacing: pace_lim = Alive[5:2], range 0..13.
  - A qualifying Tick is EN=1 and Tick=1 in MARCH_R/MARCH_L.
  - On a qualifying Tick, if pace_cnt >= pace_lim, take a step and clear pace_cnt; otherwise increment pace_cnt.
  - Result: one step every pace_lim+1 Ticks. pace_lim is sampled live, so a kill takes effect immediately. The >= comparison handles a lowered limit.
- MARCH_R step:
  - If X_Off + X_STEP > X_MAX (evaluated in XW+1 bits): drop. X_Off holds, Y_Off += Y_STEP, Dir <= 1, go to MARCH_L.
  - Else X_Off += X_STEP.
- MARCH_L step:
  - If X_Off < X_STEP: drop. X_Off holds, Y_Off += Y_STEP, Dir <= 0, go to MARCH_R.
  - Else X_Off -= X_STEP.
- Landing: if a drop makes Y_Off + Y_STEP >= Y_MAX, then Y_Off <= Y_MAX, Landed <= 1, and the state goes to LANDED.
  - LANDED holds all outputs and emits no further Step.
  - Only Restart or Rst leaves LANDED.
- Alive==0 in MARCH_R/MARCH_L: go to CLEAR at the next edge and freeze the offsets. No Step is issued, even if Tick is coincident. CLEAR is left only by Restart or Rst.
- EN=0: state, offsets, and pace_cnt hold. Any Tick arriving while EN=0 is ignored, not queued.
- Offsets never wrap: 0 <= X_Off <= X_MAX and 0 <= Y_Off <= Y_MAX at all times.

## Timing
- All outputs are registered.
- A qualifying step Tick sampled at edge k produces updated X_Off/Y_Off/Dir at edge k, and Step=1 for the cycle following edge k only. Step and the new offsets are coincident.
- A drop and the Dir flip occur at the same edge. The next step goes in the new direction.
- Landed rises at the same edge as the landing drop, alongside Step=1.
- Restart asserted with a coincident qualifying Tick: Restart wins, Step=0.
- Back-to-back Ticks on consecutive cycles with pace_lim=0 produce a step every cycle.
- Rst asserted mid-step clears all outputs asynchronously, without waiting for CLK.

## Test plan
All scenarios use default parameters.
- Reset mid-march: after X_Off reaches 24, pulse Rst low between edges -> X_Off=0, Y_Off=0, Dir=0, Landed=0 immediately; IDLE after release.
- Right sweep: Alive=3, EN=1, 17 Ticks -> X_Off goes 4, 8, ... 64 over 16 Steps. 17th Tick: X_Off=64, Y_Off=8, Dir=1, Step=1.
- Pacing: Alive=20 (pace_lim=5), 18 Ticks -> exactly 3 Steps, on Ticks 6, 12, 18. Drop Alive to 3 after Tick 13 -> next Step on Tick 14.
- Landing: Alive=3, continuous Ticks -> 15th drop sets Y_Off=120 and Landed=1. Further Ticks produce no Step. Restart -> all outputs 0.
- Wave cleared: Alive forced to 0 with a coincident Tick at X_Off=40 -> no Step, offsets frozen at 40/0. Restart, then EN=1 with Alive=3 -> marching from 0.
- Pause: EN=0 during 10 Ticks -> no output change and pace_cnt unchanged. EN=1 -> the first Tick steps per pace_lim.
